// File: rtl/rv_dm_arbiter.sv
// Shares one synchronous RAM port between the CPU load/store path and a debug host.
// The CPU normally wins; a pending host request is forced through after HOST_WAIT_MAX lost cycles.
module rv_dm_arbiter #(
  parameter int unsigned HOST_WAIT_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // CPU port
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  output logic        cpu_stall_o,
  // Debug host port
  input  logic        h_req_i,
  input  logic        h_we_i,
  input  logic [31:0] h_addr_i,
  input  logic [31:0] h_data_i,
  input  logic [3:0]  h_sel_i,
  output logic        h_ack_o,
  output logic [31:0] h_data_o,
  // Synchronous RAM port
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOST_DATA = 2'd1,
    ST_HOST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(HOST_WAIT_MAX);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_cnt_nxt;
  logic        r_host_rd;
  logic        r_h_ack;
  logic [31:0] r_h_data;
  logic        w_wait_full;
  logic        w_grant;

  assign w_wait_full = (r_wait_cnt == WAIT_MAX);

  // Reset is folded in so the RAM strobes stay quiet while rst_n_i is low.
  assign w_grant = rst_n_i && (r_state == ST_IDLE) && h_req_i &&
                   (!cpu_req_i || w_wait_full);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_host_rd  <= 1'b0;
      r_h_ack    <= 1'b0;
      r_h_data   <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_h_ack    <= (r_state == ST_HOST_DATA);
      if (w_grant) begin
        r_host_rd <= !h_we_i;
      end
      if ((r_state == ST_HOST_DATA) && r_host_rd) begin
        r_h_data <= mem_data_i;
      end
    end
  end

  // NOTE: every variable driven here is given a default first so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt    = ST_HOST_DATA;
          w_wait_cnt_nxt = 4'd0;
        end else if (h_req_i) begin
          if (!w_wait_full) begin
            w_wait_cnt_nxt = r_wait_cnt + 4'd1;
          end
        end else begin
          w_wait_cnt_nxt = 4'd0;
        end
      end
      ST_HOST_DATA: w_state_nxt = ST_HOST_ACK;
      ST_HOST_ACK:  w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // The CPU owns the RAM port in every cycle that is not a host grant.
  always_comb begin
    mem_addr_o  = cpu_addr_i;
    mem_data_o  = cpu_data_i;
    mem_sel_o   = cpu_sel_i;
    mem_we_o    = rst_n_i && cpu_req_i && cpu_we_i;
    mem_re_o    = rst_n_i && cpu_req_i && !cpu_we_i;
    cpu_stall_o = 1'b0;
    if (w_grant) begin
      mem_addr_o  = h_addr_i;
      mem_data_o  = h_data_i;
      mem_sel_o   = h_sel_i;
      mem_we_o    = h_we_i;
      mem_re_o    = !h_we_i;
      cpu_stall_o = cpu_req_i;
    end
  end

  assign h_ack_o  = r_h_ack;
  assign h_data_o = r_h_data;

endmodule

// File: tb/tb_rv_dm_arbiter.sv
// Self-checking bench for rv_dm_arbiter: single-cycle decode table plus multi-cycle host sequences,
// with expected host read data queued at issue and compared when h_ack_o pulses.
module tb_rv_dm_arbiter;

  logic        clk_i;
  logic        rst_n_i;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic [3:0]  cpu_sel_i;
  logic        cpu_stall_o;
  logic        h_req_i;
  logic        h_we_i;
  logic [31:0] h_addr_i;
  logic [31:0] h_data_i;
  logic [3:0]  h_sel_i;
  logic        h_ack_o;
  logic [31:0] h_data_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_sel_o;
  logic        mem_we_o;
  logic        mem_re_o;
  logic [31:0] mem_data_i;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] sb_q[$];
  logic [31:0] ram [0:255];

  typedef struct packed {
    logic cpu_req;
    logic cpu_we;
    logic h_req;
    logic h_we;
    logic exp_stall;
    logic exp_we;
    logic exp_re;
    logic exp_host;
  } vec_t;

  vec_t vecs[8];

  rv_dm_arbiter #(.HOST_WAIT_MAX(4)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .cpu_req_i  (cpu_req_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_stall_o(cpu_stall_o),
    .h_req_i    (h_req_i),
    .h_we_i     (h_we_i),
    .h_addr_i   (h_addr_i),
    .h_data_i   (h_data_i),
    .h_sel_i    (h_sel_i),
    .h_ack_o    (h_ack_o),
    .h_data_o   (h_data_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_sel_o  (mem_sel_o),
    .mem_we_o   (mem_we_o),
    .mem_re_o   (mem_re_o),
    .mem_data_i (mem_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Synchronous RAM model; a fixed image is reloaded whenever reset is held.
  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
      ram[64]    <= 32'hDEAD_BEEF;  // 0x100
      ram[65]    <= 32'hA5A5_0001;  // 0x104
      ram[66]    <= 32'h0BAD_F00D;  // 0x108
      ram[192]   <= 32'hCAFE_0300;  // 0x300
      mem_data_i <= 32'd0;
    end else begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_sel_o[b]) ram[mem_addr_o[9:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
        end
      end
      if (mem_re_o) mem_data_i <= ram[mem_addr_o[9:2]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_idle();
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'd0;
    cpu_data_i = 32'd0;
    cpu_sel_i  = 4'hF;
    h_req_i    = 1'b0;
    h_we_i     = 1'b0;
    h_addr_i   = 32'd0;
    h_data_i   = 32'd0;
    h_sel_i    = 4'hF;
  endtask

  // Leaves the caller at a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    set_idle();
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic host_drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    h_req_i  = 1'b1;
    h_we_i   = we;
    h_addr_i = addr;
    h_data_i = data;
    h_sel_i  = 4'hF;
  endtask

  // Called in the grant cycle; expects the ack two cycles later and pops the scoreboard.
  task automatic wait_ack(input string name, input int drop_at);
    bit          found;
    logic [31:0] exp;
    found = 1'b0;
    for (int c = 1; c <= 6 && !found; c++) begin
      @(negedge clk_i);
      #1;
      check_b({name, "_stall_busy"}, cpu_stall_o, 1'b0);
      if (h_ack_o) begin
        found = 1'b1;
        check32({name, "_latency"}, 32'(c), 32'd2);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL %s_sb: ack with empty scoreboard, h_data_o=%h", name, h_data_o);
        end else begin
          exp = sb_q.pop_front();
          check32({name, "_data"}, h_data_o, exp);
        end
        h_req_i = 1'b0;
      end else begin
        if (!cpu_req_i) check_b({name, "_no_host_strobe"}, mem_we_o | mem_re_o, 1'b0);
        if (c == drop_at) h_req_i = 1'b0;
      end
    end
    if (!found) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: no h_ack_o within 6 cycles, expected 2", name);
    end
  endtask

  initial begin
    //             cpu_req cpu_we h_req h_we | stall we re host
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    set_idle();
    rst_n_i = 1'b0;

    // Reset state, with an active CPU store that must be suppressed.
    @(negedge clk_i);
    cpu_req_i = 1'b1;
    cpu_we_i  = 1'b1;
    h_req_i   = 1'b1;
    #1;
    check_b("rst_mem_we", mem_we_o, 1'b0);
    check_b("rst_mem_re", mem_re_o, 1'b0);
    check_b("rst_stall", cpu_stall_o, 1'b0);
    @(negedge clk_i);
    #1;
    check_b("rst_h_ack", h_ack_o, 1'b0);
    check32("rst_h_data", h_data_o, 32'd0);
    set_idle();

    // Decode table, each vector in the first cycle after reset release.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      cpu_req_i  = vecs[i].cpu_req;
      cpu_we_i   = vecs[i].cpu_we;
      cpu_addr_i = 32'h0000_0040;
      cpu_data_i = 32'h1111_2222;
      h_req_i    = vecs[i].h_req;
      h_we_i     = vecs[i].h_we;
      h_addr_i   = 32'h0000_0100;
      h_data_i   = 32'h3333_4444;
      #1;
      check_b($sformatf("vec%0d_stall", i), cpu_stall_o, vecs[i].exp_stall);
      check_b($sformatf("vec%0d_we", i), mem_we_o, vecs[i].exp_we);
      check_b($sformatf("vec%0d_re", i), mem_re_o, vecs[i].exp_re);
      check32($sformatf("vec%0d_addr", i), mem_addr_o,
              vecs[i].exp_host ? 32'h0000_0100 : 32'h0000_0040);
    end

    // Host-only read of 0x100.
    do_reset();
    host_drive(1'b0, 32'h0000_0100, 32'd0);
    #1;
    check_b("hrd_re", mem_re_o, 1'b1);
    check32("hrd_addr", mem_addr_o, 32'h0000_0100);
    check_b("hrd_stall", cpu_stall_o, 1'b0);
    sb_q.push_back(32'hDEAD_BEEF);
    wait_ack("hrd", 0);

    // Starvation bound: CPU reads every cycle, host write forced through at T4.
    do_reset();
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h0000_0300;
    host_drive(1'b1, 32'h0000_0200, 32'h0000_55AA);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_b($sformatf("starve_t%0d_stall", k), cpu_stall_o, 1'b0);
      check32($sformatf("starve_t%0d_addr", k), mem_addr_o, 32'h0000_0300);
      @(negedge clk_i);
    end
    #1;
    check_b("starve_t4_stall", cpu_stall_o, 1'b1);
    check_b("starve_t4_we", mem_we_o, 1'b1);
    check32("starve_t4_addr", mem_addr_o, 32'h0000_0200);
    sb_q.push_back(32'd0);
    wait_ack("starve", 0);
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    check32("starve_ram", ram[128], 32'h0000_55AA);

    // Contention with an empty wait counter: the CPU store goes through.
    do_reset();
    cpu_req_i  = 1'b1;
    cpu_we_i   = 1'b1;
    cpu_addr_i = 32'h0000_0040;
    cpu_data_i = 32'h1234_5678;
    host_drive(1'b0, 32'h0000_0100, 32'd0);
    #1;
    check_b("cont_stall", cpu_stall_o, 1'b0);
    check_b("cont_we", mem_we_o, 1'b1);
    check32("cont_addr", mem_addr_o, 32'h0000_0040);
    @(negedge clk_i);
    set_idle();
    check32("cont_ram", ram[16], 32'h1234_5678);

    // Back-to-back host reads: grants at T and T+3.
    do_reset();
    host_drive(1'b0, 32'h0000_0104, 32'd0);
    #1;
    check_b("b2b_g0_re", mem_re_o, 1'b1);
    sb_q.push_back(32'hA5A5_0001);
    wait_ack("b2b0", 0);
    @(negedge clk_i);
    host_drive(1'b0, 32'h0000_0108, 32'd0);
    #1;
    check_b("b2b_g1_re", mem_re_o, 1'b1);
    check32("b2b_g1_addr", mem_addr_o, 32'h0000_0108);
    sb_q.push_back(32'h0BAD_F00D);
    wait_ack("b2b1", 0);

    // Reset during HOST_DATA aborts the read; a later request is served.
    do_reset();
    host_drive(1'b0, 32'h0000_0100, 32'd0);
    #1;
    check_b("rmid_grant_re", mem_re_o, 1'b1);
    @(negedge clk_i);
    rst_n_i   = 1'b0;
    h_req_i   = 1'b0;
    cpu_req_i = 1'b1;
    cpu_we_i  = 1'b1;
    #1;
    check_b("rmid_we", mem_we_o, 1'b0);
    check_b("rmid_re", mem_re_o, 1'b0);
    check_b("rmid_stall", cpu_stall_o, 1'b0);
    @(negedge clk_i);
    check_b("rmid_ack0", h_ack_o, 1'b0);
    check32("rmid_data0", h_data_o, 32'd0);
    rst_n_i = 1'b1;
    set_idle();
    @(negedge clk_i);
    check_b("rmid_ack1", h_ack_o, 1'b0);
    check32("rmid_data1", h_data_o, 32'd0);
    host_drive(1'b0, 32'h0000_0104, 32'd0);
    #1;
    check_b("rmid_after_re", mem_re_o, 1'b1);
    sb_q.push_back(32'hA5A5_0001);
    wait_ack("rmid_after", 0);

    // CPU load at T-1, host grant at T; host drops h_req_i before the ack.
    do_reset();
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'h0000_0300;
    #1;
    check_b("ilv_cpu_re", mem_re_o, 1'b1);
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    host_drive(1'b0, 32'h0000_0100, 32'd0);
    #1;
    check32("ilv_cpu_rdata", mem_data_i, 32'hCAFE_0300);
    check_b("ilv_host_re", mem_re_o, 1'b1);
    check32("ilv_host_addr", mem_addr_o, 32'h0000_0100);
    sb_q.push_back(32'hDEAD_BEEF);
    wait_ack("ilv", 1);

    check32("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
